// File: rtl/alarm_time_keeper.sv
// BCD time-of-day keeper with programmable alarm, ring/snooze FSM and a 16-bit
// Avalon-MM slave. Seconds are derived by prescaling rising edges of tick_in.
module alarm_time_keeper #(
    parameter int TICKS_PER_SEC = 10000,
    parameter int RING_SEC      = 60,
    parameter int SNOOZE_SEC    = 300
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    input  logic        tick_in,
    output logic        irq,
    output logic        alarm_out
);
    localparam int PW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int CMAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)           return 8'h00;
        else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                    return {v[7:4], v[3:0] + 4'd1};
    endfunction

    logic [3:0]    ctrl;
    logic [7:0]    hh, mm, ss;
    logic [15:0]   alarm_hm;
    logic [PW-1:0] presc;
    logic          tick_d, sec_event;
    state_t        state;
    logic [CW-1:0] ring_cnt;

    logic wr, wr_status, wr_ctrl, wr_hm, wr_s, wr_al, wr_cmd;
    logic hm_ok, s_ok, al_ok, time_wr;
    logic run, tick_edge, presc_wrap, sec_step, step_time;
    logic alarm_en_nxt, match, dismiss, snooze, ring_last, snooze_last;
    logic [7:0] ss_n, mm_n, hh_n;

    assign wr        = chipselect & ~write_n;
    assign wr_status = wr && (address == 3'd0);
    assign wr_ctrl   = wr && (address == 3'd1);
    assign wr_hm     = wr && (address == 3'd2);
    assign wr_s      = wr && (address == 3'd3);
    assign wr_al     = wr && (address == 3'd4);
    assign wr_cmd    = wr && (address == 3'd5);

    assign hm_ok   = wr_hm && bcd_ok(writedata[15:8], 8'h23) && bcd_ok(writedata[7:0], 8'h59);
    assign al_ok   = wr_al && bcd_ok(writedata[15:8], 8'h23) && bcd_ok(writedata[7:0], 8'h59);
    assign s_ok    = wr_s && bcd_ok(writedata[7:0], 8'h59);
    assign time_wr = hm_ok | s_ok;

    assign run        = ctrl[0];
    assign tick_edge  = tick_in & ~tick_d;
    assign presc_wrap = (presc == PW'(TICKS_PER_SEC - 1));
    assign sec_step   = run & tick_edge & presc_wrap;
    // A valid time write overrides the increment but the second still counts as an event.
    assign step_time  = sec_step & ~time_wr;

    assign ss_n = bcd_inc(ss, 8'h59);
    assign mm_n = (ss == 8'h59) ? bcd_inc(mm, 8'h59) : mm;
    assign hh_n = (ss == 8'h59 && mm == 8'h59) ? bcd_inc(hh, 8'h23) : hh;

    // Use the incoming alarm_en so disabling takes effect on the same edge as the write.
    assign alarm_en_nxt = wr_ctrl ? writedata[3] : ctrl[3];
    assign match        = step_time & alarm_en_nxt & (ss_n == 8'h00) & ({hh_n, mm_n} == alarm_hm);
    assign dismiss      = wr_cmd & writedata[0];
    assign snooze       = wr_cmd & writedata[1];
    assign ring_last    = (ring_cnt == CW'(RING_SEC - 1));
    assign snooze_last  = (ring_cnt == CW'(SNOOZE_SEC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl      <= '0;
            hh        <= '0;
            mm        <= '0;
            ss        <= '0;
            alarm_hm  <= '0;
            presc     <= '0;
            tick_d    <= 1'b0;
            sec_event <= 1'b0;
        end else begin
            tick_d <= tick_in;
            if (wr_ctrl) ctrl <= writedata[3:0];
            if (al_ok)   alarm_hm <= writedata;
            if (hm_ok) begin
                hh <= writedata[15:8];
                mm <= writedata[7:0];
                ss <= 8'h00;
            end else if (s_ok) begin
                ss <= writedata[7:0];
            end else if (step_time) begin
                hh <= hh_n;
                mm <= mm_n;
                ss <= ss_n;
            end
            if (time_wr)                presc <= '0;
            else if (run && tick_edge)  presc <= presc_wrap ? '0 : presc + 1'b1;
            if (sec_step)       sec_event <= 1'b1;
            else if (wr_status) sec_event <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ring_cnt  <= '0;
            alarm_out <= 1'b0;
        end else if (!alarm_en_nxt) begin
            state     <= IDLE;
            ring_cnt  <= '0;
            alarm_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (match) begin
                    state     <= RINGING;
                    ring_cnt  <= '0;
                    alarm_out <= 1'b1;
                end
                RINGING: begin
                    if (dismiss || (sec_step && ring_last)) begin
                        state     <= IDLE;
                        ring_cnt  <= '0;
                        alarm_out <= 1'b0;
                    end else if (snooze) begin
                        state     <= SNOOZE;
                        ring_cnt  <= '0;
                        alarm_out <= 1'b0;
                    end else if (sec_step) begin
                        ring_cnt  <= ring_cnt + 1'b1;
                    end
                end
                SNOOZE: begin
                    if (dismiss) begin
                        state     <= IDLE;
                        ring_cnt  <= '0;
                    end else if (sec_step && snooze_last) begin
                        state     <= RINGING;
                        ring_cnt  <= '0;
                        alarm_out <= 1'b1;
                    end else if (sec_step) begin
                        ring_cnt  <= ring_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    ring_cnt  <= '0;
                    alarm_out <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                3'd0:    readdata <= {13'b0, run, alarm_out, sec_event};
                3'd1:    readdata <= {12'b0, ctrl};
                3'd2:    readdata <= {hh, mm};
                3'd3:    readdata <= {8'b0, ss};
                3'd4:    readdata <= alarm_hm;
                default: readdata <= '0;
            endcase
        end
    end

    assign irq = (sec_event & ctrl[1]) | (alarm_out & ctrl[2]);

endmodule

// File: tb/tb_alarm_time_keeper.sv
// Directed bench for alarm_time_keeper: register table plus hand-written
// sequences for prescaling, rollover, alarm FSM, collisions and reset.
module tb_alarm_time_keeper;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic        tick_in = 1'b0;
    logic        irq;
    logic        alarm_out;

    int errors = 0;
    int checks = 0;

    alarm_time_keeper #(.TICKS_PER_SEC(4), .RING_SEC(3), .SNOOZE_SEC(2)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .tick_in(tick_in), .irq(irq), .alarm_out(alarm_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_wr;
        logic [2:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input string name, input logic [2:0] a, input logic [15:0] exp);
        address = a;
        @(posedge clk); #1;
        chk(name, readdata, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            tick_in = 1'b1;
            @(posedge clk); #1;
            tick_in = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    // One tick edge landing on the same clock as a register write.
    task automatic tick_with_wr(input logic [2:0] a, input logic [15:0] d);
        tick_in = 1'b1;
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1; tick_in = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 3'd2, 16'h1234, 16'h0000};
        vecs[1]  = '{1'b0, 3'd2, 16'h0000, 16'h1234};
        vecs[2]  = '{1'b0, 3'd3, 16'h0000, 16'h0000};
        vecs[3]  = '{1'b1, 3'd3, 16'h0045, 16'h0000};
        vecs[4]  = '{1'b0, 3'd3, 16'h0000, 16'h0045};
        vecs[5]  = '{1'b1, 3'd2, 16'h2460, 16'h0000};
        vecs[6]  = '{1'b0, 3'd2, 16'h0000, 16'h1234};
        vecs[7]  = '{1'b0, 3'd3, 16'h0000, 16'h0045};
        vecs[8]  = '{1'b1, 3'd3, 16'h005A, 16'h0000};
        vecs[9]  = '{1'b0, 3'd3, 16'h0000, 16'h0045};
        vecs[10] = '{1'b1, 3'd2, 16'h1A00, 16'h0000};
        vecs[11] = '{1'b0, 3'd2, 16'h0000, 16'h1234};
        vecs[12] = '{1'b1, 3'd4, 16'h0701, 16'h0000};
        vecs[13] = '{1'b0, 3'd4, 16'h0000, 16'h0701};
        vecs[14] = '{1'b1, 3'd4, 16'h2400, 16'h0000};
        vecs[15] = '{1'b0, 3'd4, 16'h0000, 16'h0701};
        vecs[16] = '{1'b1, 3'd1, 16'h00FF, 16'h0000};
        vecs[17] = '{1'b0, 3'd1, 16'h0000, 16'h000F};
        vecs[18] = '{1'b1, 3'd1, 16'h0000, 16'h0000};
        vecs[19] = '{1'b0, 3'd1, 16'h0000, 16'h0000};
        vecs[20] = '{1'b0, 3'd5, 16'h0000, 16'h0000};
        vecs[21] = '{1'b1, 3'd6, 16'hFFFF, 16'h0000};
        vecs[22] = '{1'b0, 3'd6, 16'h0000, 16'h0000};
        vecs[23] = '{1'b0, 3'd7, 16'h0000, 16'h0000};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_readdata", readdata, 16'h0000);
        chk("rst_irq", {15'b0, irq}, 16'h0000);
        chk("rst_alarm_out", {15'b0, alarm_out}, 16'h0000);
        reset_n = 1'b1;
        for (int a = 0; a < 5; a++) rd($sformatf("rst_reg%0d", a), 3'(a), 16'h0000);

        for (int i = 0; i < 24; i++) begin
            if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].data);
            else rd($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        end

        // Read latency: data follows the address by one clock.
        address = 3'd3;
        @(posedge clk); #1;
        address = 3'd2;
        chk("lat_before", readdata, 16'h0045);
        @(posedge clk); #1;
        chk("lat_after", readdata, 16'h1234);

        // Prescaler and sec_event.
        wr(3'd2, 16'h0000);
        wr(3'd1, 16'h0001);
        tick(8);
        rd("sec_after_8", 3'd3, 16'h0002);
        rd("status_evt", 3'd0, 16'h0005);
        wr(3'd1, 16'h0003);
        chk("irq_sec", {15'b0, irq}, 16'h0001);
        wr(3'd0, 16'h0000);
        chk("irq_cleared", {15'b0, irq}, 16'h0000);
        rd("status_clr", 3'd0, 16'h0004);
        tick(3);
        rd("sec_after_3", 3'd3, 16'h0002);

        // Day rollover; time writes zero the prescaler.
        wr(3'd2, 16'h2359);
        wr(3'd3, 16'h0059);
        tick(3);
        rd("presc_zeroed", 3'd3, 16'h0059);
        tick(1);
        rd("roll_hm", 3'd2, 16'h0000);
        rd("roll_s", 3'd3, 16'h0000);

        // run=0 ignores ticks and holds the prescaler.
        tick(2);
        wr(3'd1, 16'h0002);
        tick(5);
        rd("stopped", 3'd3, 16'h0000);
        wr(3'd1, 16'h0001);
        tick(1);
        rd("held_pre", 3'd3, 16'h0000);
        tick(1);
        rd("held_post", 3'd3, 16'h0001);

        // Alarm ring and auto-timeout.
        wr(3'd1, 16'h0000);
        wr(3'd0, 16'h0000);
        wr(3'd4, 16'h0701);
        wr(3'd2, 16'h0700);
        wr(3'd3, 16'h0059);
        wr(3'd1, 16'h000D);
        tick(4);
        chk("ring", {15'b0, alarm_out}, 16'h0001);
        chk("ring_irq", {15'b0, irq}, 16'h0001);
        rd("ring_status", 3'd0, 16'h0007);
        tick(8);
        chk("ring_2s", {15'b0, alarm_out}, 16'h0001);
        tick(4);
        chk("ring_timeout", {15'b0, alarm_out}, 16'h0000);
        chk("timeout_irq", {15'b0, irq}, 16'h0000);
        rd("timeout_status", 3'd0, 16'h0005);

        // Snooze, re-ring, then dismiss+snooze together.
        wr(3'd4, 16'h0702);
        wr(3'd2, 16'h0701);
        wr(3'd3, 16'h0059);
        tick(4);
        chk("ring2", {15'b0, alarm_out}, 16'h0001);
        wr(3'd5, 16'h0002);
        chk("snooze", {15'b0, alarm_out}, 16'h0000);
        tick(4);
        chk("snooze_1s", {15'b0, alarm_out}, 16'h0000);
        tick(4);
        chk("snooze_rering", {15'b0, alarm_out}, 16'h0001);
        wr(3'd5, 16'h0003);
        chk("dismiss", {15'b0, alarm_out}, 16'h0000);
        tick(8);
        chk("dismiss_idle", {15'b0, alarm_out}, 16'h0000);

        // Clearing alarm_en while ringing.
        wr(3'd4, 16'h0703);
        wr(3'd2, 16'h0702);
        wr(3'd3, 16'h0059);
        tick(4);
        chk("ring3", {15'b0, alarm_out}, 16'h0001);
        wr(3'd1, 16'h0005);
        chk("en_off", {15'b0, alarm_out}, 16'h0000);
        rd("en_off_ctrl", 3'd1, 16'h0005);

        // TIME_HM write colliding with sec_step.
        wr(3'd1, 16'h0001);
        wr(3'd0, 16'h0000);
        wr(3'd2, 16'h0000);
        tick(3);
        tick_with_wr(3'd2, 16'h1111);
        rd("coll_hm", 3'd2, 16'h1111);
        rd("coll_s", 3'd3, 16'h0000);
        rd("coll_evt", 3'd0, 16'h0005);
        tick(3);
        rd("coll_presc", 3'd3, 16'h0000);
        tick(1);
        rd("coll_next", 3'd3, 16'h0001);

        // STATUS write colliding with sec_step: set wins.
        wr(3'd0, 16'h0000);
        rd("stat_clr2", 3'd0, 16'h0004);
        tick(3);
        tick_with_wr(3'd0, 16'h0000);
        rd("stat_coll", 3'd0, 16'h0005);

        // Asynchronous reset while ringing.
        wr(3'd4, 16'h1112);
        wr(3'd2, 16'h1111);
        wr(3'd3, 16'h0059);
        wr(3'd1, 16'h000D);
        tick(4);
        chk("ring4", {15'b0, alarm_out}, 16'h0001);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_async_alarm", {15'b0, alarm_out}, 16'h0000);
        chk("rst_async_irq", {15'b0, irq}, 16'h0000);
        chk("rst_async_rd", readdata, 16'h0000);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int a = 0; a < 5; a++) rd($sformatf("rst2_reg%0d", a), 3'(a), 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
